// File: rtl/hex_display_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hex_display_scanner: time-multiplexed hex display feeder, frame-boundary    |
// | double buffering and per-slot blanking. Option: HEX_SCAN_LZB_EN (LZ blank). |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module hex_display_scanner #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  output logic [3:0]            digit_nibble,
  output logic [DIGITS-1:0]     digit_sel_n,
  output logic                  dp_n,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] act_val_q, act_val_d;
  logic [DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_valid_q, pend_valid_d;
  logic                frame_done_q, frame_done_d;

  logic tick;
  logic fb;
  logic blank;
  logic [DIGITS-1:0] suppress;

  assign tick  = (cnt_q == CNT_W'(PRESCALE - 1));
  assign fb    = tick && (idx_q == IDX_W'(DIGITS - 1));
  assign blank = (cnt_q < CNT_W'(BLANK_CYCLES));

  always_comb begin
    cnt_d        = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    act_val_d    = act_val_q;
    act_dp_d     = act_dp_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    frame_done_d = fb;

    if (tick) begin
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end

    // A load coinciding with the boundary bypasses the pending buffer
    if (fb) begin
      if (load) begin
        act_val_d = value;
        act_dp_d  = dp_in;
      end else if (pend_valid_q) begin
        act_val_d = pend_val_q;
        act_dp_d  = pend_dp_q;
      end
      pend_valid_d = 1'b0;
    end else if (load) begin
      pend_val_d   = value;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef HEX_SCAN_LZB_EN
  logic zero_run;

  // Walk from the most significant digit down; digit 0 is never suppressed
  always_comb begin
    suppress = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run    = zero_run && (act_val_q[4*i +: 4] == 4'h0);
      suppress[i] = zero_run && !act_dp_q[i];
    end
  end
`else
  assign suppress = '0;
`endif

  always_comb begin
    digit_nibble = 4'h0;
    dp_n         = 1'b1;
    digit_sel_n  = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        digit_nibble = act_val_q[4*i +: 4];
        dp_n         = ~act_dp_q[i];
        if (!blank && !suppress[i]) begin
          digit_sel_n[i] = 1'b0;
        end
      end
    end
  end

  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_hex_display_scanner: directed self-checking bench, DIGITS=4, PRESCALE=8, |
// | BLANK_CYCLES=2. Rev 1.0                                                     |
// +----------------------------------------------------------------------------+
module tb_hex_display_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic [3:0]  digit_nibble;
  logic [3:0]  digit_sel_n;
  logic        dp_n;
  logic        frame_done;

  int cyc    = 0;
  int passed = 0;
  int total  = 0;

  hex_display_scanner #(
    .DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .load(load),
    .digit_nibble(digit_nibble), .digit_sel_n(digit_sel_n),
    .dp_n(dp_n), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Leaves the bench at the negedge of cycle 0 (first cycle with rst low)
  task automatic reset_dut();
    rst  = 1'b1;
    load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic go_to(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    @(negedge clk);
    cyc++;
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (digit_sel_n !== 4'b1111 || digit_nibble !== 4'h0 || dp_n !== 1'b1 || frame_done !== 1'b0) begin
      $display("FAIL reset_outputs: sel=%b nib=%h dp_n=%b fd=%b, required sel=1111 nib=0 dp_n=1 fd=0",
               digit_sel_n, digit_nibble, dp_n, frame_done);
    end else passed++;
  endtask

  task automatic test_scan_timing();
    int          cyc_t[9] = '{0, 1, 2, 7, 8, 10, 24, 26, 33};
    logic [3:0]  sel_t[9] = '{4'b1111, 4'b1111, 4'b1110, 4'b1110, 4'b1111,
                              4'b1101, 4'b1111, 4'b0111, 4'b1111};
    reset_dut();
    for (int i = 0; i < 9; i++) begin
      go_to(cyc_t[i]);
      total++;
      if (digit_sel_n !== sel_t[i] || digit_nibble !== 4'h0) begin
        $display("FAIL scan_sel@%0d: sel=%b nib=%h, required sel=%b nib=0",
                 cyc_t[i], digit_sel_n, digit_nibble, sel_t[i]);
      end else passed++;
    end
    reset_dut();
    go_to(31);
    total++;
    if (frame_done !== 1'b0) $display("FAIL frame_done@31: got %b, required 0", frame_done);
    else passed++;
    go_to(32);
    total++;
    if (frame_done !== 1'b1) $display("FAIL frame_done@32: got %b, required 1", frame_done);
    else passed++;
    go_to(33);
    total++;
    if (frame_done !== 1'b0) $display("FAIL frame_done@33: got %b, required 0", frame_done);
    else passed++;
  endtask

  task automatic test_load_boundary();
    int         cyc_t[6] = '{26, 31, 32, 40, 48, 56};
    logic [3:0] nib_t[6] = '{4'h0, 4'h0, 4'hF, 4'hE, 4'hE, 4'hB};
    reset_dut();
    go_to(5);
    do_load(16'hBEEF, 4'h0);
    for (int i = 0; i < 6; i++) begin
      go_to(cyc_t[i]);
      total++;
      if (digit_nibble !== nib_t[i])
        $display("FAIL beef_nib@%0d: got %h, required %h", cyc_t[i], digit_nibble, nib_t[i]);
      else passed++;
    end
    go_to(58);
    total++;
    if (digit_sel_n !== 4'b0111 || dp_n !== 1'b1)
      $display("FAIL beef_sel@58: sel=%b dp_n=%b, required sel=0111 dp_n=1", digit_sel_n, dp_n);
    else passed++;
  endtask

  task automatic test_last_write_wins();
    int         cyc_t[5] = '{26, 32, 40, 48, 56};
    logic [3:0] nib_t[5] = '{4'h0, 4'h8, 4'h7, 4'h6, 4'h5};
    reset_dut();
    go_to(10);
    do_load(16'h1234, 4'h0);
    go_to(20);
    do_load(16'h5678, 4'h0);
    for (int i = 0; i < 5; i++) begin
      go_to(cyc_t[i]);
      total++;
      if (digit_nibble !== nib_t[i])
        $display("FAIL lww_nib@%0d: got %h, required %h", cyc_t[i], digit_nibble, nib_t[i]);
      else passed++;
    end
  endtask

  task automatic test_bypass();
    int         cyc_t[5] = '{32, 40, 64, 72, 88};
    logic [3:0] nib_t[5] = '{4'h5, 4'hA, 4'h5, 4'hA, 4'hA};
    reset_dut();
    go_to(20);
    do_load(16'h1111, 4'h0);
    go_to(31);
    do_load(16'hA5A5, 4'h0);
    for (int i = 0; i < 5; i++) begin
      go_to(cyc_t[i]);
      total++;
      if (digit_nibble !== nib_t[i])
        $display("FAIL bypass_nib@%0d: got %h, required %h", cyc_t[i], digit_nibble, nib_t[i]);
      else passed++;
    end
  endtask

  task automatic test_dp();
    int         cyc_t[5]  = '{34, 42, 48, 50, 58};
    logic       dpn_t[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] sel_t[5]  = '{4'b1110, 4'b1101, 4'b1111, 4'b1011, 4'b0111};
    reset_dut();
    go_to(1);
    do_load(16'h0000, 4'b0100);
    for (int i = 0; i < 5; i++) begin
      go_to(cyc_t[i]);
      total++;
      if (dp_n !== dpn_t[i] || digit_sel_n !== sel_t[i])
        $display("FAIL dp@%0d: dp_n=%b sel=%b, required dp_n=%b sel=%b",
                 cyc_t[i], dp_n, digit_sel_n, dpn_t[i], sel_t[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_frame();
    reset_dut();
    go_to(5);
    do_load(16'hBEEF, 4'hF);
    go_to(44);
    do_load(16'h7777, 4'h0);
    go_to(45);
    total++;
    if (digit_nibble !== 4'hE)
      $display("FAIL pre_rst_nib@45: got %h, required e", digit_nibble);
    else passed++;
    rst   = 1'b1;
    value = 16'hFFFF;
    dp_in = 4'hF;
    load  = 1'b1;
    @(negedge clk);
    total++;
    if (digit_sel_n !== 4'b1111 || digit_nibble !== 4'h0 || dp_n !== 1'b1)
      $display("FAIL rst_mid@46: sel=%b nib=%h dp_n=%b, required sel=1111 nib=0 dp_n=1",
               digit_sel_n, digit_nibble, dp_n);
    else passed++;
    load = 1'b0;
    rst  = 1'b0;
    cyc  = 0;
    go_to(2);
    total++;
    if (digit_sel_n !== 4'b1110)
      $display("FAIL rst_restart@2: sel=%b, required 1110", digit_sel_n);
    else passed++;
    go_to(42);
    total++;
    if (digit_nibble !== 4'h0 || dp_n !== 1'b1)
      $display("FAIL rst_discard@42: nib=%h dp_n=%b, required nib=0 dp_n=1", digit_nibble, dp_n);
    else passed++;
  endtask

  task automatic test_leading_zero();
    logic [3:0] sel3, sel2;
`ifdef HEX_SCAN_LZB_EN
    sel3 = 4'b1111;
    sel2 = 4'b1111;
`else
    sel3 = 4'b0111;
    sel2 = 4'b1011;
`endif
    reset_dut();
    go_to(3);
    do_load(16'h0042, 4'h0);
    go_to(34);
    total++;
    if (digit_sel_n !== 4'b1110 || digit_nibble !== 4'h2)
      $display("FAIL lz_d0@34: sel=%b nib=%h, required sel=1110 nib=2", digit_sel_n, digit_nibble);
    else passed++;
    go_to(42);
    total++;
    if (digit_sel_n !== 4'b1101 || digit_nibble !== 4'h4)
      $display("FAIL lz_d1@42: sel=%b nib=%h, required sel=1101 nib=4", digit_sel_n, digit_nibble);
    else passed++;
    go_to(52);
    total++;
    if (digit_sel_n !== sel2)
      $display("FAIL lz_d2@52: sel=%b, required %b", digit_sel_n, sel2);
    else passed++;
    go_to(60);
    total++;
    if (digit_sel_n !== sel3)
      $display("FAIL lz_d3@60: sel=%b, required %b", digit_sel_n, sel3);
    else passed++;
    do_load(16'h0000, 4'h0);
    go_to(66);
    total++;
    if (digit_sel_n !== 4'b1110 || digit_nibble !== 4'h0)
      $display("FAIL lz_zero_d0@66: sel=%b nib=%h, required sel=1110 nib=0", digit_sel_n, digit_nibble);
    else passed++;
    go_to(74);
    total++;
    if (digit_sel_n !== {sel3[0], sel3[0], 1'b0, 1'b1} && 1'b0) begin end
`ifdef HEX_SCAN_LZB_EN
    if (digit_sel_n !== 4'b1111)
      $display("FAIL lz_zero_d1@74: sel=%b, required 1111", digit_sel_n);
    else passed++;
`else
    if (digit_sel_n !== 4'b1101)
      $display("FAIL lz_zero_d1@74: sel=%b, required 1101", digit_sel_n);
    else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_scan_timing();
    test_load_boundary();
    test_last_write_wins();
    test_bypass();
    test_dp();
    test_reset_mid_frame();
    test_leading_zero();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
